// File: rtl/cache_control_pkg.sv
// Shared types and constants for the cache controller.
// State encodings are plain logic constants so older code can compare against them directly.
package cache_control_pkg;

   typedef logic [1:0] cache_state_t;

   localparam cache_state_t IDLE      = 2'd0;
   localparam cache_state_t WRITEBACK = 2'd1;
   localparam cache_state_t ALLOCATE  = 2'd2;

   // pmem address source select
   localparam logic [1:0] PMEM_SEL_WB_W1 = 2'b00;
   localparam logic [1:0] PMEM_SEL_WB_W2 = 2'b01;
   localparam logic [1:0] PMEM_SEL_CPU   = 2'b10;

endpackage

// File: rtl/cache_control_perf_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, cleared by reset.
module cache_control_perf_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Increment on request unless already saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way, 8-set, 16-byte-line write-back cache.
// Serves CPU hits with zero wait states; on a miss writes back a dirty LRU victim, then refills it.
// Optional feature macro: CACHE_SILENT_STORE_EN suppresses array writes for full-word stores of
// unchanged data.
module cache_control
   import cache_control_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // CPU port
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       mem_byte_enable,
   output logic             mem_resp,
   // physical memory port
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   // datapath status
   input  logic             ishit_w1,
   input  logic             ishit_w2,
   input  logic             isdirty_w1,
   input  logic             isdirty_w2,
   input  logic             lru_out,
   input  logic             dirty_compare_w1_out,
   input  logic             dirty_compare_w2_out,
   // datapath controls
   output logic             load_dirty_w1,
   output logic             load_dirty_w2,
   output logic             load_valid_w1,
   output logic             load_valid_w2,
   output logic             load_tag_w1,
   output logic             load_tag_w2,
   output logic             load_datastore_w1,
   output logic             load_datastore_w2,
   output logic             dirty_array_w1_in,
   output logic             dirty_array_w2_in,
   output logic             load_lru,
   output logic             lru_in,
   output logic             datastore_in_mux_sel,
   output logic [1:0]       pmem_address_mux_sel,
   // performance counters
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   cache_state_t state_q, state_d;
   logic         miss_pend_q, miss_pend_d;
   logic         hit_inc, miss_inc;
   logic         req, hit, way2, silent;

   assign req  = mem_read | mem_write;
   assign hit  = ishit_w1 | ishit_w2;
   // A double hit is illegal; resolve it as way 2.
   assign way2 = ishit_w2;

`ifdef CACHE_SILENT_STORE_EN
   assign silent = mem_write && (mem_byte_enable == 2'b11) &&
                   (way2 ? dirty_compare_w2_out : dirty_compare_w1_out);
`else
   logic unused_silent;
   assign unused_silent = ^{mem_byte_enable, dirty_compare_w1_out, dirty_compare_w2_out};
   assign silent = 1'b0;
`endif

   // Next-state, counter events and every datapath strobe.
   always_comb begin
      state_d              = state_q;
      miss_pend_d          = miss_pend_q;
      hit_inc              = 1'b0;
      miss_inc             = 1'b0;
      mem_resp             = 1'b0;
      pmem_read            = 1'b0;
      pmem_write           = 1'b0;
      load_dirty_w1        = 1'b0;
      load_dirty_w2        = 1'b0;
      load_valid_w1        = 1'b0;
      load_valid_w2        = 1'b0;
      load_tag_w1          = 1'b0;
      load_tag_w2          = 1'b0;
      load_datastore_w1    = 1'b0;
      load_datastore_w2    = 1'b0;
      dirty_array_w1_in    = 1'b0;
      dirty_array_w2_in    = 1'b0;
      load_lru             = 1'b0;
      lru_in               = 1'b0;
      datastore_in_mux_sel = 1'b0;
      pmem_address_mux_sel = PMEM_SEL_CPU;

      case (state_q)
         IDLE: begin
            if (req && hit) begin
               mem_resp    = 1'b1;
               load_lru    = 1'b1;
               lru_in      = ~way2;
               hit_inc     = ~miss_pend_q;
               miss_pend_d = 1'b0;
               if (mem_write) begin
                  datastore_in_mux_sel = 1'b1;
                  if (!silent) begin
                     load_datastore_w1 = ~way2;
                     load_datastore_w2 = way2;
                     load_dirty_w1     = ~way2;
                     load_dirty_w2     = way2;
                     dirty_array_w1_in = ~way2;
                     dirty_array_w2_in = way2;
                  end
               end
            end else if (req) begin
               miss_inc    = 1'b1;
               miss_pend_d = 1'b1;
               state_d     = (lru_out ? isdirty_w2 : isdirty_w1) ? WRITEBACK : ALLOCATE;
            end else begin
               // Request abandoned during a miss: the next request starts fresh.
               miss_pend_d = 1'b0;
            end
         end
         WRITEBACK: begin
            pmem_write           = 1'b1;
            pmem_address_mux_sel = {1'b0, lru_out};
            if (pmem_resp) begin
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_datastore_w1 = ~lru_out;
               load_datastore_w2 = lru_out;
               load_tag_w1       = ~lru_out;
               load_tag_w2       = lru_out;
               load_valid_w1     = ~lru_out;
               load_valid_w2     = lru_out;
               load_dirty_w1     = ~lru_out;
               load_dirty_w2     = lru_out;
               state_d           = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and miss-pending registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         miss_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         miss_pend_q <= miss_pend_d;
      end
   end

   cache_control_perf_counter #(
      .CNT_W (CNT_W)
   ) u_hit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit_inc),
      .count (hit_count)
   );

   cache_control_perf_counter #(
      .CNT_W (CNT_W)
   ) u_miss_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (miss_inc),
      .count (miss_count)
   );

   // The datapath must never report both ways hitting on a live request.
   a_no_double_hit : assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == IDLE) && req && ishit_w1 && ishit_w2));

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control (CNT_W=4 so saturation is reachable).
module tb_cache_control;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mem_read, mem_write, mem_resp;
   logic [1:0]       mem_byte_enable;
   logic             pmem_read, pmem_write, pmem_resp;
   logic             ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
   logic             dirty_compare_w1_out, dirty_compare_w2_out;
   logic             load_dirty_w1, load_dirty_w2, load_valid_w1, load_valid_w2;
   logic             load_tag_w1, load_tag_w2, load_datastore_w1, load_datastore_w2;
   logic             dirty_array_w1_in, dirty_array_w2_in, load_lru, lru_in;
   logic             datastore_in_mux_sel;
   logic [1:0]       pmem_address_mux_sel;
   logic [CNT_W-1:0] hit_count, miss_count;

   always #5 clk = ~clk;

   cache_control #(
      .CNT_W (CNT_W)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mem_read             (mem_read),
      .mem_write            (mem_write),
      .mem_byte_enable      (mem_byte_enable),
      .mem_resp             (mem_resp),
      .pmem_read            (pmem_read),
      .pmem_write           (pmem_write),
      .pmem_resp            (pmem_resp),
      .ishit_w1             (ishit_w1),
      .ishit_w2             (ishit_w2),
      .isdirty_w1           (isdirty_w1),
      .isdirty_w2           (isdirty_w2),
      .lru_out              (lru_out),
      .dirty_compare_w1_out (dirty_compare_w1_out),
      .dirty_compare_w2_out (dirty_compare_w2_out),
      .load_dirty_w1        (load_dirty_w1),
      .load_dirty_w2        (load_dirty_w2),
      .load_valid_w1        (load_valid_w1),
      .load_valid_w2        (load_valid_w2),
      .load_tag_w1          (load_tag_w1),
      .load_tag_w2          (load_tag_w2),
      .load_datastore_w1    (load_datastore_w1),
      .load_datastore_w2    (load_datastore_w2),
      .dirty_array_w1_in    (dirty_array_w1_in),
      .dirty_array_w2_in    (dirty_array_w2_in),
      .load_lru             (load_lru),
      .lru_in               (lru_in),
      .datastore_in_mux_sel (datastore_in_mux_sel),
      .pmem_address_mux_sel (pmem_address_mux_sel),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   // {load_lru, lru_in, lds_w1, lds_w2, ldd_w1, ldd_w2, din_w1, din_w2, ds_sel}
   typedef logic [8:0] strobes_t;
   localparam strobes_t RdHitW1 = 9'b1_1_0_0_0_0_0_0_0;
   localparam strobes_t WrHitW1 = 9'b1_1_1_0_1_0_1_0_1;
   localparam strobes_t WrHitW2 = 9'b1_0_0_1_0_1_0_1_1;
   localparam strobes_t SilentW1 = 9'b1_1_0_0_0_0_0_0_1;

   strobes_t         exp_q[$];
   int               tests = 0;
   int               fails = 0;
   logic [CNT_W-1:0] exp_hits, exp_miss;

   function automatic strobes_t cur_strobes();
      return {load_lru, lru_in, load_datastore_w1, load_datastore_w2, load_dirty_w1,
              load_dirty_w2, dirty_array_w1_in, dirty_array_w2_in, datastore_in_mux_sel};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Scoreboard consumer: wait (bounded) for mem_resp and compare against the oldest expectation.
   task automatic sb_expect_resp(input string name, input int budget);
      bit       seen = 1'b0;
      strobes_t exp;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (mem_resp === 1'b1) seen = 1'b1;
      end
      tests++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
      if (!seen) begin
         fails++;
         $display("FAIL %s: no mem_resp within %0d cycles, required a pulse", name, budget);
      end else if (cur_strobes() !== exp) begin
         fails++;
         $display("FAIL %s: strobes %b, required %b", name, cur_strobes(), exp);
      end
   endtask

   task automatic idle_inputs();
      mem_read = 0; mem_write = 0; mem_byte_enable = 2'b11; pmem_resp = 0;
      ishit_w1 = 0; ishit_w2 = 0; isdirty_w1 = 0; isdirty_w2 = 0; lru_out = 0;
      dirty_compare_w1_out = 0; dirty_compare_w2_out = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      exp_hits = '0;
      exp_miss = '0;
   endtask

   task automatic check_counts(input string name);
      tests++;
      if (hit_count !== exp_hits) begin
         fails++;
         $display("FAIL %s hit_count: got %0d, required %0d", name, hit_count, exp_hits);
      end
      tests++;
      if (miss_count !== exp_miss) begin
         fails++;
         $display("FAIL %s miss_count: got %0d, required %0d", name, miss_count, exp_miss);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      tests++;
      if ({mem_resp, pmem_read, pmem_write, cur_strobes()} !== 12'b0) begin
         fails++;
         $display("FAIL reset strobes: got %b, required 0",
                  {mem_resp, pmem_read, pmem_write, cur_strobes()});
      end
      tests++;
      if (pmem_address_mux_sel !== 2'b10) begin
         fails++;
         $display("FAIL reset pmem_sel: got %b, required 10", pmem_address_mux_sel);
      end
      check_counts("reset");
   endtask

   task automatic test_read_hit();
      @(posedge clk); #1;
      mem_read = 1; ishit_w1 = 1;
      exp_q.push_back(RdHitW1);
      exp_hits = sat_inc(exp_hits);
      sb_expect_resp("read_hit_w1", 1);
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      tests++;
      if (mem_resp !== 1'b0) begin
         fails++;
         $display("FAIL resp_pulse: mem_resp %b after request dropped, required 0", mem_resp);
      end
      check_counts("read_hit_w1");
   endtask

   // Read and write both high: the write must win.
   task automatic test_write_hit();
      @(posedge clk); #1;
      mem_read = 1; mem_write = 1; mem_byte_enable = 2'b11; ishit_w2 = 1;
      exp_q.push_back(WrHitW2);
      exp_hits = sat_inc(exp_hits);
      sb_expect_resp("write_hit_w2", 1);
      @(posedge clk); #1 idle_inputs();
      check_counts("write_hit_w2");
   endtask

   task automatic test_clean_miss();
      @(posedge clk); #1;
      mem_read = 1; lru_out = 0;
      @(negedge clk);
      tests++;
      if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
         fails++;
         $display("FAIL clean_miss_idle: resp/rd/wr %b, required 000",
                  {mem_resp, pmem_read, pmem_write});
      end
      exp_miss = sat_inc(exp_miss);
      @(negedge clk);
      tests++;
      if ({pmem_read, pmem_write, pmem_address_mux_sel} !== 4'b1010) begin
         fails++;
         $display("FAIL clean_miss_alloc: rd/wr/sel %b, required 1010",
                  {pmem_read, pmem_write, pmem_address_mux_sel});
      end
      repeat (4) @(posedge clk);
      #1 pmem_resp = 1;
      @(negedge clk);
      tests++;
      if ({pmem_read, load_datastore_w1, load_tag_w1, load_valid_w1, load_dirty_w1,
           dirty_array_w1_in, datastore_in_mux_sel, load_datastore_w2, load_tag_w2,
           mem_resp} !== 10'b1_1111_0_0_0_0_0) begin
         fails++;
         $display("FAIL clean_miss_fill: got %b, required 1111100000",
                  {pmem_read, load_datastore_w1, load_tag_w1, load_valid_w1, load_dirty_w1,
                   dirty_array_w1_in, datastore_in_mux_sel, load_datastore_w2, load_tag_w2,
                   mem_resp});
      end
      @(posedge clk); #1;
      pmem_resp = 0; ishit_w1 = 1;
      exp_q.push_back(RdHitW1);
      sb_expect_resp("clean_miss_complete", 1);
      @(posedge clk); #1 idle_inputs();
      check_counts("clean_miss");
   endtask

   task automatic test_dirty_miss();
      @(posedge clk); #1;
      mem_write = 1; mem_byte_enable = 2'b11; lru_out = 1; isdirty_w2 = 1;
      exp_miss = sat_inc(exp_miss);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({pmem_write, pmem_read, pmem_address_mux_sel} !== 4'b1001) begin
         fails++;
         $display("FAIL dirty_miss_wb: wr/rd/sel %b, required 1001",
                  {pmem_write, pmem_read, pmem_address_mux_sel});
      end
      repeat (2) @(posedge clk);
      #1 pmem_resp = 1;
      @(negedge clk);
      tests++;
      if ({pmem_write, load_datastore_w2, load_tag_w2} !== 3'b100) begin
         fails++;
         $display("FAIL dirty_miss_wb_end: wr/lds2/ldt2 %b, required 100",
                  {pmem_write, load_datastore_w2, load_tag_w2});
      end
      @(posedge clk); #1 pmem_resp = 0;
      @(negedge clk);
      tests++;
      if ({pmem_read, pmem_write, pmem_address_mux_sel} !== 4'b1010) begin
         fails++;
         $display("FAIL dirty_miss_alloc: rd/wr/sel %b, required 1010",
                  {pmem_read, pmem_write, pmem_address_mux_sel});
      end
      @(posedge clk); #1 pmem_resp = 1;
      @(negedge clk);
      tests++;
      if ({load_datastore_w2, load_tag_w2, load_valid_w2, load_dirty_w2, dirty_array_w2_in,
           load_datastore_w1} !== 6'b1111_0_0) begin
         fails++;
         $display("FAIL dirty_miss_fill: got %b, required 111100",
                  {load_datastore_w2, load_tag_w2, load_valid_w2, load_dirty_w2,
                   dirty_array_w2_in, load_datastore_w1});
      end
      @(posedge clk); #1;
      pmem_resp = 0; ishit_w2 = 1;
      exp_q.push_back(WrHitW2);
      sb_expect_resp("dirty_miss_complete", 1);
      @(posedge clk); #1 idle_inputs();
      check_counts("dirty_miss");
   endtask

   task automatic test_reset_in_writeback();
      @(posedge clk); #1;
      mem_read = 1; lru_out = 0; isdirty_w1 = 1;
      @(posedge clk); #1;
      tests++;
      if (pmem_write !== 1'b1) begin
         fails++;
         $display("FAIL rst_wb_entry: pmem_write %b, required 1", pmem_write);
      end
      #1 rst_n = 0;
      #1;
      tests++;
      if ({pmem_write, pmem_read, pmem_address_mux_sel} !== 4'b0010) begin
         fails++;
         $display("FAIL rst_wb_async: wr/rd/sel %b, required 0010",
                  {pmem_write, pmem_read, pmem_address_mux_sel});
      end
      exp_hits = '0;
      exp_miss = '0;
      check_counts("rst_wb");
      idle_inputs();
      @(posedge clk); #1 rst_n = 1;
   endtask

   task automatic test_silent_store();
      @(posedge clk); #1;
      mem_write = 1; mem_byte_enable = 2'b11; ishit_w1 = 1; dirty_compare_w1_out = 1;
`ifdef CACHE_SILENT_STORE_EN
      exp_q.push_back(SilentW1);
`else
      exp_q.push_back(WrHitW1);
`endif
      exp_hits = sat_inc(exp_hits);
      sb_expect_resp("store_be11_equal", 1);
      @(posedge clk); #1 mem_byte_enable = 2'b01;
      exp_q.push_back(WrHitW1);
      exp_hits = sat_inc(exp_hits);
      sb_expect_resp("store_be01_equal", 1);
      @(posedge clk); #1 idle_inputs();
      check_counts("silent_store");
   endtask

   task automatic test_back_to_back_saturation();
      apply_reset();
      @(posedge clk); #1;
      mem_read = 1; ishit_w1 = 1;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         exp_q.push_back(RdHitW1);
         exp_hits = sat_inc(exp_hits);
         sb_expect_resp("b2b_hit", 1);
      end
      @(posedge clk); #1 idle_inputs();
      tests++;
      if (hit_count !== 4'hF) begin
         fails++;
         $display("FAIL saturate: hit_count %h, required f", hit_count);
      end
      check_counts("saturate");
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_reset_in_writeback();
      test_silent_store();
      test_back_to_back_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
